// File: rtl/fifo_chk_pkg.sv
// Shared definitions for the FIFO read-side checker: FSM encoding,
// default geometry and counter widths.
package fifo_chk_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FULL = 3'd1,
        SETTLE    = 3'd2,
        READ      = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_BURST_LEN  = 254;
    localparam int DEF_SETTLE_CYC = 10;
    localparam int ERR_CNT_W      = 16;
    localparam int BURST_CNT_W    = 16;

endpackage

// File: rtl/fifo_rd_cmp.sv
// Expected-value generator and comparator for the FIFO read checker.
// Keeps the per-burst word count and a saturating error counter that
// also absorbs burst-length errors reported by the controlling FSM.
module fifo_rd_cmp
    import fifo_chk_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                CNT_W     = 8,
    parameter logic [DATA_W-1:0] PAT_START = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [DATA_W-1:0]    data,
    input  logic                 load,
    input  logic                 len_err,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [DATA_W-1:0]  exp_val;
    logic [ERR_CNT_W:0] err_sum;
    logic [ERR_CNT_W-1:0] err_next;

    assign mismatch = valid && (data != exp_val);

    // Expected pattern and word count: load restarts the burst, each valid word advances both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_val <= PAT_START;
            rd_cnt  <= '0;
        end else if (load) begin
            exp_val <= PAT_START;
            rd_cnt  <= '0;
        end else if (valid) begin
            exp_val <= exp_val + DATA_W'(1);
            rd_cnt  <= rd_cnt + CNT_W'(1);
        end
    end

    // Saturating sum of data mismatches and length errors; one extra bit catches overflow.
    always_comb begin
        err_next = err_cnt;
        err_sum  = {1'b0, err_cnt} + (ERR_CNT_W+1)'(mismatch) + (ERR_CNT_W+1)'(len_err);
        if (err_sum[ERR_CNT_W]) begin
            err_next = '1;
        end else begin
            err_next = err_sum[ERR_CNT_W-1:0];
        end
    end

    // Error counter survives burst restarts; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_next;
        end
    end

endmodule

// File: rtl/fifo_rd_check.sv
// Read-side consumer for the dual-clock FIFO. Waits for full, lets the
// flags settle, drains the FIFO and checks an incrementing pattern.
// Build option: define FIFO_CHK_FWFT_EN for a first-word-fall-through
// FIFO (data valid with rd_en, no DRAIN state); otherwise data arrives
// one rd_clk after rd_en.
// Handshake: a word is consumed on every rd_clk edge where fifo_rd_en
// is high; fifo_rd_en is never high while empty is high.
module fifo_rd_check
    import fifo_chk_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                BURST_LEN  = DEF_BURST_LEN,
    parameter int                CNT_W      = 8,
    parameter int                SETTLE_CYC = DEF_SETTLE_CYC,
    parameter logic [DATA_W-1:0] PAT_START  = '0
) (
    input  logic                   rd_clk,
    input  logic                   rst_n,
    input  logic                   rd_rst_busy,
    input  logic                   full,
    input  logic                   empty,
    input  logic [DATA_W-1:0]      fifo_rd_data,
    output logic                   fifo_rd_en,
    output logic                   chk_done,
    output logic                   chk_err,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [BURST_CNT_W-1:0] burst_cnt,
    output logic [CNT_W-1:0]       rd_cnt
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [SET_W-1:0] settle_cnt;
    logic             settle_done;
    logic             abort;
    logic             len_err;
    logic             cmp_valid;
    logic             cmp_load;
    logic             mismatch;

    assign settle_done = (settle_cnt == SET_W'(SETTLE_CYC - 1));
    // A FIFO read-side reset while a burst is in flight throws the burst away.
    assign abort       = rd_rst_busy && (state_q != IDLE);
    assign len_err     = (state_q == DONE) && (rd_cnt != CNT_W'(BURST_LEN));
    assign cmp_load    = (state_q == IDLE) || abort || ((state_q == SETTLE) && settle_done);

`ifdef FIFO_CHK_FWFT_EN
    assign cmp_valid = fifo_rd_en;
`else
    logic rd_en_d1;

    // One-cycle read latency: the registered enable marks the cycle dout is valid.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_d1 <= 1'b0;
        end else begin
            rd_en_d1 <= fifo_rd_en;
        end
    end

    // Only compare inside a live burst so a read issued just before an abort is ignored.
    assign cmp_valid = rd_en_d1 && ((state_q == READ) || (state_q == DRAIN));
`endif

    // State register.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; abort overrides every transition.
    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        chk_done   = 1'b0;
        case (state_q)
            IDLE:      if (!rd_rst_busy) state_d = WAIT_FULL;
            WAIT_FULL: if (full) state_d = SETTLE;
            SETTLE:    if (settle_done) state_d = READ;
            READ: begin
                fifo_rd_en = !empty;
`ifdef FIFO_CHK_FWFT_EN
                if (empty) state_d = DONE;
`else
                if (empty) state_d = DRAIN;
`endif
            end
            DRAIN:     state_d = DONE;
            DONE: begin
                chk_done = 1'b1;
                state_d  = WAIT_FULL;
            end
            default:   state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Settle timer runs only in SETTLE and holds at its terminal count.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state_q != SETTLE) begin
            settle_cnt <= '0;
        end else if (!settle_done) begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end
    end

    // Burst counter (wrapping) and sticky error flag.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
            chk_err   <= 1'b0;
        end else begin
            if (state_q == DONE) burst_cnt <= burst_cnt + BURST_CNT_W'(1);
            if (mismatch || len_err) chk_err <= 1'b1;
        end
    end

    fifo_rd_cmp #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .PAT_START (PAT_START)
    ) u_cmp (
        .clk      (rd_clk),
        .rst_n    (rst_n),
        .valid    (cmp_valid),
        .data     (fifo_rd_data),
        .load     (cmp_load),
        .len_err  (len_err),
        .mismatch (mismatch),
        .rd_cnt   (rd_cnt),
        .err_cnt  (err_cnt)
    );

endmodule

// File: tb/tb_fifo_rd_check.sv
// Directed bench for fifo_rd_check. A behavioural FIFO feeds two checker
// instances: one with PAT_START=0 and one with PAT_START=8'hF0 that sees
// the same data offset by 8'hF0, so its expected stream wraps F0..FF,00..
// Honours FIFO_CHK_FWFT_EN for the FIFO read timing.
module tb_fifo_rd_check;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              rd_rst_busy;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [DATA_W-1:0] fifo_rd_data_w;

    logic              fifo_rd_en,  fifo_rd_en_w;
    logic              chk_done,    chk_done_w;
    logic              chk_err,     chk_err_w;
    logic [15:0]       err_cnt,     err_cnt_w;
    logic [15:0]       burst_cnt,   burst_cnt_w;
    logic [CNT_W-1:0]  rd_cnt,      rd_cnt_w;

    fifo_rd_check #(.PAT_START(8'h00)) dut (
        .rd_clk(clk), .rst_n(rst_n), .rd_rst_busy(rd_rst_busy), .full(full),
        .empty(empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .chk_done(chk_done), .chk_err(chk_err), .err_cnt(err_cnt),
        .burst_cnt(burst_cnt), .rd_cnt(rd_cnt)
    );

    fifo_rd_check #(.PAT_START(8'hF0)) dut_w (
        .rd_clk(clk), .rst_n(rst_n), .rd_rst_busy(rd_rst_busy), .full(full),
        .empty(empty), .fifo_rd_data(fifo_rd_data_w), .fifo_rd_en(fifo_rd_en_w),
        .chk_done(chk_done_w), .chk_err(chk_err_w), .err_cnt(err_cnt_w),
        .burst_cnt(burst_cnt_w), .rd_cnt(rd_cnt_w)
    );

    // ---------------- FIFO model ----------------
    logic [DATA_W-1:0] mem [0:511];
    logic [9:0]        wr_ptr;
    logic [9:0]        rd_ptr;
    logic              busy_d;
    logic [DATA_W-1:0] dout_q;

    assign empty = (wr_ptr == rd_ptr);
    assign fifo_rd_data_w = fifo_rd_data + 8'hF0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            busy_d <= 1'b0;
            dout_q <= '0;
        end else begin
            busy_d <= rd_rst_busy;
            if (busy_d && !rd_rst_busy) begin
                rd_ptr <= wr_ptr;
            end else if (fifo_rd_en) begin
                dout_q <= mem[rd_ptr[8:0]];
                rd_ptr <= rd_ptr + 10'd1;
            end
        end
    end

`ifdef FIFO_CHK_FWFT_EN
    assign fifo_rd_data = mem[rd_ptr[8:0]];
`else
    assign fifo_rd_data = dout_q;
`endif

    // ---------------- monitor ----------------
    int               reads;
    int               viol;
    int               done_cnt;
    int               done_cnt_w;
    logic             err_seen;
    logic [CNT_W-1:0] err_rd_cnt;
    logic [CNT_W-1:0] obs_len [0:7];

    always @(negedge clk) begin
        if (!rst_n) begin
            reads      <= 0;
            viol       <= 0;
            done_cnt   <= 0;
            done_cnt_w <= 0;
            err_seen   <= 1'b0;
            err_rd_cnt <= '0;
        end else begin
            if (fifo_rd_en) reads <= reads + 1;
            if ((fifo_rd_en && empty) || (fifo_rd_en != fifo_rd_en_w)) viol <= viol + 1;
            if (chk_done) begin
                if (done_cnt < 8) obs_len[done_cnt] <= rd_cnt;
                done_cnt <= done_cnt + 1;
            end
            if (chk_done_w) done_cnt_w <= done_cnt_w + 1;
            if (chk_err && !err_seen) begin
                err_seen   <= 1'b1;
                err_rd_cnt <= rd_cnt;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int               n_checks;
    int               n_fail;
    logic [CNT_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        full        = 1'b0;
        rd_rst_busy = 1'b0;
        wr_ptr      = '0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("rst_rd_en",     32'(fifo_rd_en), 0);
        check("rst_chk_done",  32'(chk_done),   0);
        check("rst_chk_err",   32'(chk_err),    0);
        check("rst_err_cnt",   32'(err_cnt),    0);
        check("rst_burst_cnt", 32'(burst_cnt),  0);
        check("rst_rd_cnt",    32'(rd_cnt),     0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic fill(input int n, input int corrupt);
        logic [9:0] idx;
        for (int k = 0; k < n; k++) begin
            idx = wr_ptr + 10'(k);
            mem[idx[8:0]] = (k == corrupt) ? 8'hFF : 8'(k);
        end
        wr_ptr = wr_ptr + 10'(n);
    endtask

    task automatic pulse_full();
        tick(2);
        full = 1'b1;
        tick(1);
        full = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        int cyc;
        start = done_cnt;
        cyc   = 0;
        while (done_cnt == start && cyc < 1000) begin
            @(posedge clk);
            cyc++;
        end
        if (done_cnt == start) check("done_timeout", 0, 1);
        #1;
        tick(1);
    endtask

    task automatic run_burst(input int n, input int corrupt, input logic [CNT_W-1:0] exp_len);
        fill(n, corrupt);
        pulse_full();
        exp_q.push_back(exp_len);
        wait_done();
    endtask

    task automatic close_scenario(input string tag, input int n_bursts);
        int k;
        @(negedge clk);
        check({tag, "_done_cnt"},   32'(done_cnt),   32'(n_bursts));
        check({tag, "_done_cnt_w"}, 32'(done_cnt_w), 32'(n_bursts));
        check({tag, "_rd_en_viol"}, 32'(viol),       0);
        k = 0;
        while (exp_q.size() > 0) begin
            check({tag, "_burst_len"}, 32'(obs_len[k]), 32'(exp_q.pop_front()));
            k++;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        rd_rst_busy = 1'b0;
        full        = 1'b0;
        wr_ptr      = '0;

        // Clean burst 0..253.
        do_reset();
        run_burst(254, -1, 8'd254);
        close_scenario("clean", 1);
        check("clean_reads",       32'(reads),       254);
        check("clean_burst_cnt",   32'(burst_cnt),   1);
        check("clean_chk_err",     32'(chk_err),     0);
        check("clean_err_cnt",     32'(err_cnt),     0);
        check("clean_rd_cnt",      32'(rd_cnt),      254);
        check("wrap_clean_err",    32'(err_cnt_w),   0);
        check("wrap_clean_burst",  32'(burst_cnt_w), 1);

        // Word 100 corrupted to FF.
        do_reset();
        run_burst(254, 100, 8'd254);
        close_scenario("corrupt", 1);
        check("corrupt_err_cnt",   32'(err_cnt),     1);
        check("corrupt_chk_err",   32'(chk_err),     1);
        check("corrupt_align",     32'(err_rd_cnt),  101);
        check("corrupt_burst_cnt", 32'(burst_cnt),   1);
        check("wrap_corrupt_err",  32'(err_cnt_w),   1);

        // Short burst of 200 words.
        do_reset();
        run_burst(200, -1, 8'd200);
        close_scenario("short", 1);
        check("short_err_cnt",     32'(err_cnt),     1);
        check("short_chk_err",     32'(chk_err),     1);
        check("short_rd_cnt",      32'(rd_cnt),      200);
        check("wrap_short_err",    32'(err_cnt_w),   1);

        // Read-side reset after 50 reads, then a clean burst.
        do_reset();
        fill(254, -1);
        pulse_full();
        begin
            int cyc;
            cyc = 0;
            while (reads < 50 && cyc < 600) begin
                @(posedge clk);
                cyc++;
            end
            if (reads < 50) check("abort_wait_timeout", 0, 1);
        end
        #1;
        rd_rst_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_rd_en",       32'(fifo_rd_en),  0);
        check("abort_not_empty",   32'(empty),       0);
        check("abort_rd_cnt",      32'(rd_cnt),      0);
        tick(3);
        rd_rst_busy = 1'b0;
        tick(3);
        check("abort_no_done",     32'(done_cnt),    0);
        run_burst(254, -1, 8'd254);
        close_scenario("abort", 1);
        check("abort_burst_cnt",   32'(burst_cnt),   1);
        check("abort_chk_err",     32'(chk_err),     0);
        check("abort_err_cnt",     32'(err_cnt),     0);

        // Three back-to-back clean bursts.
        do_reset();
        for (int b = 0; b < 3; b++) run_burst(254, -1, 8'd254);
        close_scenario("b2b", 3);
        check("b2b_burst_cnt",     32'(burst_cnt),   3);
        check("b2b_err_cnt",       32'(err_cnt),     0);
        check("b2b_chk_err",       32'(chk_err),     0);
        check("wrap_b2b_burst",    32'(burst_cnt_w), 3);
        check("wrap_b2b_err",      32'(err_cnt_w),   0);
        check("wrap_b2b_chk_err",  32'(chk_err_w),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
